// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus bundle: both ROM ports, the redirect input from execute
// and the decode-facing valid/ready bundle.
interface riscv_fetch_if;
   logic [31:0] fw_rom_addr;
   logic [31:0] fw_rom_out;
   logic [31:0] rom_addr;
   logic [31:0] rom_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   modport master (
      output fw_rom_addr, rom_addr, out_valid, out_pc, out_instr, out_fault,
      input  fw_rom_out, rom_out, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  fw_rom_addr, rom_addr, out_valid, out_pc, out_instr, out_fault,
      output fw_rom_out, rom_out, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: owns the PC, maps it onto firmware/program ROM
// windows and hands one registered {pc, instr, fault} bundle per cycle to decode.
module riscv_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] FW_BASE  = 32'h0000_0000,
   parameter logic [31:0] FW_SIZE  = 32'd512,
   parameter logic [31:0] ROM_BASE = 32'h0000_1000,
   parameter logic [31:0] ROM_SIZE = 32'd512,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               reset_n,
   riscv_fetch_if.master      bus
);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        valid_reg, valid_next;
   logic [31:0] opc_reg, opc_next;
   logic [31:0] instr_reg, instr_next;
   logic        fault_reg, fault_next;

   logic [31:0] fw_off, rom_off;
   logic        fw_hit, rom_hit, pc_fault, fetch_en;
   logic [31:0] fetch_word;

   // Unsigned offset compare covers both window bounds in one test;
   // firmware takes precedence if the windows ever overlap.
   assign fw_off   = pc_reg - FW_BASE;
   assign rom_off  = pc_reg - ROM_BASE;
   assign fw_hit   = (fw_off < FW_SIZE);
   assign rom_hit  = !fw_hit && (rom_off < ROM_SIZE);
   assign pc_fault = !(fw_hit || rom_hit) || (pc_reg[1:0] != 2'b00);

   assign bus.fw_rom_addr = fw_hit  ? (fw_off  & ~32'h3) : 32'h0;
   assign bus.rom_addr    = rom_hit ? (rom_off & ~32'h3) : 32'h0;
   assign fetch_word      = fw_hit  ? bus.fw_rom_out : bus.rom_out;

   assign fetch_en = !valid_reg || bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
         valid_reg <= 1'b0;
         opc_reg   <= 32'h0;
         instr_reg <= NOP;
         fault_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         valid_reg <= valid_next;
         opc_reg   <= opc_next;
         instr_reg <= instr_next;
         fault_reg <= fault_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      valid_next = valid_reg;
      opc_next   = opc_reg;
      instr_next = instr_reg;
      fault_next = fault_reg;

      // A redirect kills the pending bundle and fetches nothing this cycle.
      if (bus.redirect_valid) begin
         pc_next    = bus.redirect_pc;
         valid_next = 1'b0;
         state_next = RUN;
      end else begin
         case (state_reg)
            RUN: begin
               if (fetch_en) begin
                  valid_next = 1'b1;
                  opc_next   = pc_reg;
                  if (pc_fault) begin
                     instr_next = NOP;
                     fault_next = 1'b1;
                     state_next = FAULT;
                  end else begin
                     instr_next = fetch_word;
                     fault_next = 1'b0;
                     pc_next    = pc_reg + 32'd4;
                  end
               end
            end
            FAULT: begin
               if (valid_reg && bus.out_ready)
                  valid_next = 1'b0;
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign bus.out_valid = valid_reg;
   assign bus.out_pc    = opc_reg;
   assign bus.out_instr = instr_reg;
   assign bus.out_fault = fault_reg;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: ROM models are bench arrays, every expected
// bundle is hand-computed from the fill patterns below.
module tb_riscv_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic reset_n;
   riscv_fetch_if bus ();

   riscv_fetch dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Firmware word i = F000_0000+i, program ROM word i = A000_0000+i.
   logic [31:0] fw_mem  [0:127];
   logic [31:0] rom_mem [0:127];
   assign bus.fw_rom_out = fw_mem[bus.fw_rom_addr[8:2]];
   assign bus.rom_out    = rom_mem[bus.rom_addr[8:2]];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   always @(negedge clk)
      if (reset_n && bus.out_valid && bus.out_ready)
         $display("xfer pc=%h instr=%h fault=%b", bus.out_pc, bus.out_instr, bus.out_fault);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      end
      n_checks++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", bus.out_instr, NOP); end
      n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.out_pc); end
      n_checks++; if (bus.out_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.out_fault); end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected 1", i, bus.out_valid); end
         n_checks++; if (bus.out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc%0d: got %h expected %h", i, bus.out_pc, i * 4); end
         n_checks++; if (bus.out_instr !== 32'hF000_0000 + 32'(i)) begin n_fail++; $display("FAIL seq_instr%0d: got %h expected %h", i, bus.out_instr, 32'hF000_0000 + 32'(i)); end
         n_checks++; if (bus.out_fault !== 1'b0) begin n_fail++; $display("FAIL seq_fault%0d: got %b expected 0", i, bus.out_fault); end
         n_checks++; if (bus.fw_rom_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL seq_align%0d: got %b expected 00", i, bus.fw_rom_addr[1:0]); end
      end
   endtask

   task automatic test_stall();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (bus.out_pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc%0d: got %h expected 00000008", i, bus.out_pc); end
         n_checks++; if (bus.out_instr !== 32'hF000_0002) begin n_fail++; $display("FAIL stall_instr%0d: got %h expected f0000002", i, bus.out_instr); end
         n_checks++; if (bus.fw_rom_addr !== 32'hC) begin n_fail++; $display("FAIL stall_fetchaddr%0d: got %h expected 0000000c", i, bus.fw_rom_addr); end
      end
      bus.out_ready = 1'b1;
      tick();
      n_checks++; if (bus.out_pc !== 32'hC) begin n_fail++; $display("FAIL stall_release_pc: got %h expected 0000000c", bus.out_pc); end
      n_checks++; if (bus.out_instr !== 32'hF000_0003) begin n_fail++; $display("FAIL stall_release_instr: got %h expected f0000003", bus.out_instr); end
   endtask

   task automatic test_redirect_rom();
      redirect(32'h1000);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL redir_rom_addr: got %h expected 0", bus.rom_addr); end
      n_checks++; if (bus.fw_rom_addr !== 32'h0) begin n_fail++; $display("FAIL redir_fw_addr: got %h expected 0", bus.fw_rom_addr); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid: got %b expected 1", bus.out_valid); end
      n_checks++; if (bus.out_pc !== 32'h1000) begin n_fail++; $display("FAIL redir_pc: got %h expected 00001000", bus.out_pc); end
      n_checks++; if (bus.out_instr !== 32'hA000_0000) begin n_fail++; $display("FAIL redir_instr: got %h expected a0000000", bus.out_instr); end
      tick();
      n_checks++; if (bus.out_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL redir_next_instr: got %h expected a0000001", bus.out_instr); end
      n_checks++; if (bus.rom_addr !== 32'h8) begin n_fail++; $display("FAIL redir_next_addr: got %h expected 00000008", bus.rom_addr); end
   endtask

   task automatic test_back_to_back();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0040;
      tick();
      bus.redirect_pc    = 32'h0000_1010;
      tick();
      bus.redirect_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.rom_addr !== 32'h10) begin n_fail++; $display("FAIL b2b_rom_addr: got %h expected 00000010", bus.rom_addr); end
      tick();
      n_checks++; if (bus.out_pc !== 32'h1010) begin n_fail++; $display("FAIL b2b_pc: got %h expected 00001010", bus.out_pc); end
      n_checks++; if (bus.out_instr !== 32'hA000_0004) begin n_fail++; $display("FAIL b2b_instr: got %h expected a0000004", bus.out_instr); end
   endtask

   task automatic test_unmapped();
      redirect(32'h0800);
      n_checks++; if (bus.fw_rom_addr !== 32'h0 || bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL unmap_addrs: got %h/%h expected 0/0", bus.fw_rom_addr, bus.rom_addr); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL unmap_valid: got %b expected 1", bus.out_valid); end
      n_checks++; if (bus.out_pc !== 32'h0800) begin n_fail++; $display("FAIL unmap_pc: got %h expected 00000800", bus.out_pc); end
      n_checks++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL unmap_instr: got %h expected %h", bus.out_instr, NOP); end
      n_checks++; if (bus.out_fault !== 1'b1) begin n_fail++; $display("FAIL unmap_fault: got %b expected 1", bus.out_fault); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL unmap_idle%0d: got %b expected 0", i, bus.out_valid); end
      end
      redirect(32'h0);
      tick();
      n_checks++; if (bus.out_pc !== 32'h0 || bus.out_fault !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL unmap_resume: got pc=%h fault=%b valid=%b expected 0/0/1", bus.out_pc, bus.out_fault, bus.out_valid); end
      n_checks++; if (bus.out_instr !== 32'hF000_0000) begin n_fail++; $display("FAIL unmap_resume_instr: got %h expected f0000000", bus.out_instr); end
   endtask

   task automatic test_misaligned();
      redirect(32'h1002);
      n_checks++; if (bus.rom_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL mis_align_a: got %b expected 00", bus.rom_addr[1:0]); end
      bus.out_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bus.out_pc !== 32'h1002 || bus.out_fault !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mis_bundle%0d: got pc=%h fault=%b valid=%b expected 1002/1/1", i, bus.out_pc, bus.out_fault, bus.out_valid); end
         n_checks++; if (bus.rom_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL mis_align%0d: got %b expected 00", i, bus.rom_addr[1:0]); end
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_drain: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_window_end();
      redirect(32'h11F8);
      tick();
      n_checks++; if (bus.out_instr !== 32'hA000_007E) begin n_fail++; $display("FAIL end_11f8: got %h expected a000007e", bus.out_instr); end
      tick();
      n_checks++; if (bus.out_pc !== 32'h11FC || bus.out_fault !== 1'b0) begin n_fail++; $display("FAIL end_11fc: got pc=%h fault=%b expected 11fc/0", bus.out_pc, bus.out_fault); end
      n_checks++; if (bus.out_instr !== 32'hA000_007F) begin n_fail++; $display("FAIL end_11fc_instr: got %h expected a000007f", bus.out_instr); end
      n_checks++; if (bus.rom_addr !== 32'h0) begin n_fail++; $display("FAIL end_unmapped_addr: got %h expected 0", bus.rom_addr); end
      tick();
      n_checks++; if (bus.out_pc !== 32'h1200 || bus.out_fault !== 1'b1 || bus.out_instr !== NOP) begin n_fail++; $display("FAIL end_1200: got pc=%h fault=%b instr=%h expected 1200/1/%h", bus.out_pc, bus.out_fault, bus.out_instr, NOP); end
   endtask

   task automatic test_reset_mid();
      redirect(32'h0010);
      tick();
      bus.out_ready = 1'b0;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10) begin n_fail++; $display("FAIL mid_pre: got valid=%b pc=%h expected 1/10", bus.out_valid, bus.out_pc); end
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.out_instr !== NOP || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL mid_async_regs: got instr=%h pc=%h expected %h/0", bus.out_instr, bus.out_pc, NOP); end
      n_checks++; if (bus.fw_rom_addr !== 32'h0) begin n_fail++; $display("FAIL mid_async_pc: got %h expected 0", bus.fw_rom_addr); end
      bus.out_ready = 1'b1;
      tick();
      reset_n = 1'b1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'hF000_0000) begin n_fail++; $display("FAIL mid_restart: got valid=%b pc=%h instr=%h expected 1/0/f0000000", bus.out_valid, bus.out_pc, bus.out_instr); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         fw_mem[i]  = 32'hF000_0000 + 32'(i);
         rom_mem[i] = 32'hA000_0000 + 32'(i);
      end
      test_reset();
      test_stall();
      test_redirect_rom();
      test_back_to_back();
      test_unmapped();
      test_misaligned();
      test_window_end();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
